// File: rtl/lab2_proc_test_mem_responder.sv
// ---------------------------------------------------------------------------
// lab2_proc_test_mem_responder
//
// Backing-memory responder for the processor's 4B imem/dmem request streams.
// Each accepted request is executed against an internal word array during
// its accept cycle. The response is pushed into a 2-entry FIFO, so it is
// visible one cycle later.
//
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous reset, active low
//   istream_msg  in   77  {type_[3], opaque[8], addr[32], len[2], data[32]}
//   istream_val  in   1   request valid
//   istream_rdy  out  1   request can be accepted (FIFO not full)
//   ostream_msg  out  47  {type_[3], opaque[8], test[2], len[2], data[32]}
//   ostream_val  out  1   response valid (FIFO not empty)
//   ostream_rdy  in   1   consumer takes the head response
//
// Parameters
//   p_num_words  words in the array (power of two, >= 4)
//
// Build option
//   MEM_RESPONDER_AMO_EN  when defined, types 3..7 are full-word atomics
//                         (add, and, or, swap, signed min) that return the
//                         old word. Otherwise they are unsupported types.
// ---------------------------------------------------------------------------
module lab2_proc_test_mem_responder #(
  parameter int unsigned p_num_words = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [76:0] istream_msg,
  input  logic        istream_val,
  output logic        istream_rdy,
  output logic [46:0] ostream_msg,
  output logic        ostream_val,
  input  logic        ostream_rdy
);

  localparam int unsigned c_idx_w = $clog2(p_num_words);

  localparam logic [2:0] c_type_read  = 3'd0;
  localparam logic [2:0] c_type_write = 3'd1;
  localparam logic [2:0] c_type_init  = 3'd2;
`ifdef MEM_RESPONDER_AMO_EN
  localparam logic [2:0] c_type_add   = 3'd3;
  localparam logic [2:0] c_type_and   = 3'd4;
  localparam logic [2:0] c_type_or    = 3'd5;
  localparam logic [2:0] c_type_swap  = 3'd6;
  localparam logic [2:0] c_type_min   = 3'd7;
`endif

  // -------------------------------------------------------------------------
  // Request fields
  // -------------------------------------------------------------------------
  logic [2:0]         req_type;
  logic [7:0]         req_opaque;
  logic [31:0]        req_addr;
  logic [1:0]         req_len;
  logic [31:0]        req_data;
  logic [c_idx_w-1:0] req_idx;
  logic [1:0]         req_off;

  assign {req_type, req_opaque, req_addr, req_len, req_data} = istream_msg;
  assign req_idx = req_addr[2 +: c_idx_w];
  assign req_off = req_addr[1:0];

  // Address bits above the array index are ignored, so addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:2+c_idx_w];

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       accept;
  logic       deq;

  // Gated by reset so the stream looks stalled while reset is held and is
  // ready again as soon as it is released.
  assign istream_rdy = reset & (count_q < 2'd2);
  assign ostream_val = (count_q != 2'd0);
  assign accept      = istream_val & istream_rdy;
  assign deq         = ostream_val & ostream_rdy;

  // -------------------------------------------------------------------------
  // Word array and sub-word data paths
  // -------------------------------------------------------------------------
  logic [31:0] mem_q [p_num_words];

  logic [31:0] word_old;
  logic [2:0]  req_nbytes;
  logic [3:0]  byte_en;
  logic [31:0] rd_data;
  logic [31:0] shift_data;
  logic [31:0] wr_word;

  always_comb begin
    word_old   = mem_q[req_idx];
    req_nbytes = (req_len == 2'd0) ? 3'd4 : {1'b0, req_len};

    // Bytes at or beyond the word boundary are never enabled, so a write
    // that runs off the end is truncated instead of wrapping.
    byte_en = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if ((i >= int'(req_off)) && (i < int'(req_off) + int'(req_nbytes))) begin
        byte_en[i] = 1'b1;
      end
    end

    // Shifting right brings zeros in from the top. Bytes past the word
    // boundary therefore read as zero even before the length mask.
    rd_data = word_old >> {req_off, 3'b000};
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(req_nbytes)) begin
        rd_data[8*i +: 8] = 8'h00;
      end
    end

    shift_data = req_data << {req_off, 3'b000};
    wr_word    = word_old;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        wr_word[8*i +: 8] = shift_data[8*i +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Access decode
  // -------------------------------------------------------------------------
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] resp_data;
  logic [1:0]  resp_test;

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = wr_word;
    resp_data = 32'h0;
    resp_test = 2'b00;
    case (req_type)
      c_type_read: begin
        resp_data = rd_data;
      end
      c_type_write, c_type_init: begin
        mem_we = accept;
      end
`ifdef MEM_RESPONDER_AMO_EN
      c_type_add: begin
        mem_we    = accept;
        mem_wdata = word_old + req_data;
        resp_data = word_old;
      end
      c_type_and: begin
        mem_we    = accept;
        mem_wdata = word_old & req_data;
        resp_data = word_old;
      end
      c_type_or: begin
        mem_we    = accept;
        mem_wdata = word_old | req_data;
        resp_data = word_old;
      end
      c_type_swap: begin
        mem_we    = accept;
        mem_wdata = req_data;
        resp_data = word_old;
      end
      c_type_min: begin
        mem_we    = accept;
        mem_wdata = ($signed(word_old) < $signed(req_data)) ? word_old : req_data;
        resp_data = word_old;
      end
`endif
      default: begin
        resp_test = 2'b11;
      end
    endcase
  end

  // The array has no reset: contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[req_idx] <= mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // 2-entry response FIFO
  // -------------------------------------------------------------------------
  logic [46:0] fifo_q [2];
  logic [46:0] fifo_d [2];
  logic        wr_ptr_q;
  logic        wr_ptr_d;
  logic        rd_ptr_q;
  logic        rd_ptr_d;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      fifo_d[wr_ptr_q] = {req_type, req_opaque, resp_test, req_len, resp_data};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (deq) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // A simultaneous accept and dequeue cancels out and leaves the count as is.
    count_d = count_q + {1'b0, accept} - {1'b0, deq};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign ostream_msg = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_lab2_proc_test_mem_responder.sv
module tb_lab2_proc_test_mem_responder;

  localparam int NW = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [76:0] istream_msg = '0;
  logic        istream_val = 1'b0;
  logic        istream_rdy;
  logic [46:0] ostream_msg;
  logic        ostream_val;
  logic        ostream_rdy = 1'b1;

  always #5 clk = ~clk;

  lab2_proc_test_mem_responder #(.p_num_words(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_msg (istream_msg),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .ostream_msg (ostream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy)
  );

  logic [31:0] ref_mem [NW];
  logic [46:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          rand_rdy = 1'b0;

`ifdef MEM_RESPONDER_AMO_EN
  localparam bit AMO = 1'b1;
`else
  localparam bit AMO = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: works on bytes and lengths, then packs the response.
  task automatic model_req(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                           input logic [1:0] len, input logic [31:0] data,
                           output logic [46:0] resp);
    int          idx;
    int          off;
    int          n;
    logic [31:0] old;
    logic [31:0] rd;
    logic [1:0]  test;
    idx  = int'(addr[31:2] % 30'(NW));
    off  = int'(addr[1:0]);
    n    = (len == 2'd0) ? 4 : int'(len);
    old  = ref_mem[idx];
    rd   = 32'h0;
    test = 2'b00;
    if (t == 3'd0) begin
      for (int k = 0; k < n; k++)
        if (off + k < 4) rd[8*k +: 8] = old[8*(off+k) +: 8];
    end else if (t == 3'd1 || t == 3'd2) begin
      for (int k = 0; k < n; k++)
        if (off + k < 4) ref_mem[idx][8*(off+k) +: 8] = data[8*k +: 8];
    end else if (AMO) begin
      rd = old;
      case (t)
        3'd3:    ref_mem[idx] = old + data;
        3'd4:    ref_mem[idx] = old & data;
        3'd5:    ref_mem[idx] = old | data;
        3'd6:    ref_mem[idx] = data;
        default: ref_mem[idx] = ($signed(old) < $signed(data)) ? old : data;
      endcase
    end else begin
      test = 2'b11;
    end
    resp = {t, op, test, len, rd};
  endtask

  task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                      input logic [1:0] len, input logic [31:0] data,
                      input bit use_exp, input logic [1:0] e_test, input logic [31:0] e_data);
    logic [46:0] r;
    bit          done;
    done = 1'b0;
    @(posedge clk); #1;
    if (rand_rdy) ostream_rdy = 1'($urandom_range(0, 1));
    istream_val = 1'b1;
    istream_msg = {t, op, addr, len, data};
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (istream_rdy) begin
        model_req(t, op, addr, len, data, r);
        if (use_exp) r = {t, op, e_test, len, e_data};
        exp_q.push_back(r);
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (rand_rdy) ostream_rdy = 1'($urandom_range(0, 1));
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got istream_rdy=0 for 200 cycles expected accept (msg %h)", istream_msg);
    end
  endtask

  task automatic send_m(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] data);
    send(t, op, addr, len, data, 1'b0, 2'b00, 32'h0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    istream_val = 1'b0;
    if (rand_rdy) ostream_rdy = 1'($urandom_range(0, 1));
  endtask

  // Monitor: every dequeue is compared against the head of the scoreboard.
  always @(negedge clk) begin
    logic [46:0] e;
    if (reset && ostream_val && ostream_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got %h expected no response", ostream_msg);
      end else begin
        e = exp_q.pop_front();
        chk("resp", 64'(ostream_msg), 64'(e));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ostream_val", 64'(ostream_val), 64'd0);
    chk("rst_istream_rdy", 64'(istream_rdy), 64'd0);
    reset = 1'b1;
    #1;
    chk("rdy_after_release", 64'(istream_rdy), 64'd1);

    // Preload every word so the model and the array agree.
    for (int i = 0; i < NW; i++) send_m(3'd2, 8'(i), 32'(i * 4), 2'd0, $urandom);

    // Write then read, with a 1-cycle latency check on the write.
    send(3'd1, 8'h05, 32'h10, 2'd0, 32'hDEADBEEF, 1'b1, 2'b00, 32'h0);
    idle();
    @(negedge clk);
    chk("latency_val", 64'(ostream_val), 64'd1);
    send(3'd0, 8'h06, 32'h10, 2'd0, 32'h0, 1'b1, 2'b00, 32'hDEADBEEF);
    // Read accepted on the cycle right after a write to the same word.
    send(3'd1, 8'h07, 32'h50, 2'd0, 32'hCAFEF00D, 1'b1, 2'b00, 32'h0);
    send(3'd0, 8'h08, 32'h50, 2'd0, 32'h0, 1'b1, 2'b00, 32'hCAFEF00D);
    idle();

    // Backpressure: two requests fill the FIFO, the third stalls.
    repeat (3) @(posedge clk);
    #1 ostream_rdy = 1'b0;
    send(3'd0, 8'h11, 32'h10, 2'd0, 32'h0, 1'b1, 2'b00, 32'hDEADBEEF);
    send(3'd0, 8'h12, 32'h50, 2'd0, 32'h0, 1'b1, 2'b00, 32'hCAFEF00D);
    @(posedge clk); #1;
    istream_msg = {3'd0, 8'h13, 32'h10, 2'd0, 32'h0};
    @(negedge clk);
    chk("bp_third_rdy", 64'(istream_rdy), 64'd0);
    chk("bp_ostream_val", 64'(ostream_val), 64'd1);
    @(posedge clk); #1;
    ostream_rdy = 1'b1;
    send(3'd0, 8'h13, 32'h10, 2'd0, 32'h0, 1'b1, 2'b00, 32'hDEADBEEF);

    // Sub-word reads with edge truncation.
    send(3'd1, 8'h20, 32'h20, 2'd0, 32'h11223344, 1'b1, 2'b00, 32'h0);
    send(3'd0, 8'h21, 32'h21, 2'd1, 32'h0, 1'b1, 2'b00, 32'h00000033);
    send(3'd0, 8'h22, 32'h22, 2'd2, 32'h0, 1'b1, 2'b00, 32'h00001122);
    send(3'd0, 8'h23, 32'h23, 2'd2, 32'h0, 1'b1, 2'b00, 32'h00000011);

    // Sub-word writes, including one running off the word end.
    send(3'd1, 8'h30, 32'h30, 2'd0, 32'h0, 1'b1, 2'b00, 32'h0);
    send(3'd1, 8'h31, 32'h31, 2'd2, 32'h0000AABB, 1'b1, 2'b00, 32'h0);
    send(3'd0, 8'h32, 32'h30, 2'd0, 32'h0, 1'b1, 2'b00, 32'h00AABB00);
    send(3'd1, 8'h33, 32'h33, 2'd3, 32'h77665544, 1'b1, 2'b00, 32'h0);
    send(3'd0, 8'h34, 32'h30, 2'd0, 32'h0, 1'b1, 2'b00, 32'h44AABB00);
    idle();

    // Reset mid-stream with two queued responses.
    repeat (3) @(posedge clk);
    #1 ostream_rdy = 1'b0;
    send_m(3'd0, 8'h41, 32'h10, 2'd0, 32'h0);
    send_m(3'd0, 8'h42, 32'h50, 2'd0, 32'h0);
    idle();
    @(negedge clk);
    chk("queued_val", 64'(ostream_val), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ostream_val", 64'(ostream_val), 64'd0);
    chk("midrst_istream_rdy", 64'(istream_rdy), 64'd0);
    exp_q.delete();
    ostream_rdy = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rerelease_rdy", 64'(istream_rdy), 64'd1);
    send(3'd0, 8'h43, 32'h10, 2'd0, 32'h0, 1'b1, 2'b00, 32'hDEADBEEF);

    // Type 3 (AMO_ADD when enabled, unsupported otherwise).
    send(3'd1, 8'h50, 32'h40, 2'd0, 32'd5, 1'b1, 2'b00, 32'h0);
    send(3'd3, 8'h51, 32'h40, 2'd0, 32'd3, 1'b1, AMO ? 2'b00 : 2'b11, AMO ? 32'd5 : 32'd0);
    send(3'd0, 8'h52, 32'h40, 2'd0, 32'h0, 1'b1, 2'b00, AMO ? 32'd8 : 32'd5);

    // Random traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send_m(3'($urandom_range(0, 7)), 8'($urandom), $urandom, 2'($urandom), $urandom);
    end
    rand_rdy = 1'b0;
    idle();
    @(posedge clk); #1;
    ostream_rdy = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("final_ostream_val", 64'(ostream_val), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lab2_proc_test_mem_responder.md
Name: lab2_proc_test_mem_responder

Overview:
- Memory-side responder for the 4B memory request/response streams the pipelined processor issues on its imem and dmem ports.
- Accepts mem_req_4B_t messages on a val/rdy input stream.
- Performs the access on an internal word-addressed array and returns mem_resp_4B_t messages on a val/rdy output stream.
- Used as a single-port backing memory in processor and cache test harnesses. Two instances serve imem and dmem.

Parameters:
- p_num_words, 256, number of 32-bit words in the array; power of 2, minimum 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- istream_msg  in  77  mem_req_4B_t {type_[3], opaque[8], addr[32], len[2], data[32]}.
- istream_val  in  1  request valid.
- istream_rdy  out  1  responder can accept a request.
- ostream_msg  out  47  mem_resp_4B_t {type_[3], opaque[8], test[2], len[2], data[32]}.
- ostream_val  out  1  response valid.
- ostream_rdy  in  1  consumer accepts response.

Behaviour:
- Reset (reset==0, asynchronous):
  - Response FIFO emptied: ostream_val=0.
  - istream_rdy=0 while reset is asserted; istream_rdy=1 on the first cycle after deassertion.
  - Array contents are not affected by reset.
  - Assertion mid-transfer discards all queued responses and any in-progress accept.
- Structure: 2-entry response FIFO (write ptr, read ptr, 2-bit count).
  - istream_rdy = (count < 2). The same-cycle dequeue is not credited.
  - ostream_val = (count != 0). ostream_msg = FIFO head.
- Transfers: request accept = istream_val & istream_rdy. Response dequeue = ostream_val & ostream_rdy.
  - Simultaneous accept and dequeue: count unchanged, both pointers advance.
- Latency: exactly 1 cycle.
  - Request accepted at edge N; its response is visible with ostream_val=1 in cycle N+1.
  - Full throughput (1 req/cycle) when ostream_rdy is held high.
- Order: responses are returned in request order. The FIFO never overflows.
- Address mapping:
  - Word index = addr[2 +: log2(p_num_words)]; upper address bits are ignored (modulo wrap).
  - Byte offset = addr[1:0].
- Length: len 0 means 4 bytes; len 1, 2, 3 mean 1, 2, 3 bytes.
- READ (type_ 0):
  - data = (word >> 8*offset) masked to len bytes, zero-extended.
  - Bytes that would lie past the word boundary read as 0.
- WRITE (1) and INIT (2):
  - Write the low len bytes of data starting at the byte offset.
  - Bytes past the word boundary are dropped; no wrap into the next word.
  - The array updates at the accept edge.
  - Response data = 0.
  - INIT is identical to WRITE.
- Read-after-write: a read accepted on the cycle after a write to the same word returns the new value.
- Every response:
  - type_ and opaque are echoed from the request.
  - len is echoed.
  - test = 2'b00 for supported types.
- Unsupported type_: no array change. The response has data=0 and test=2'b11, and is still returned in order.

Optional Feature:
- MEM_RESPONDER_AMO_EN
- Defined:
  - Types 3..7 are read-modify-write on the full word; addr[1:0] and len are ignored. Types: 3 AMO_ADD (wraps mod 2^32), 4 AMO_AND, 5 AMO_OR, 6 AMO_SWAP, 7 AMO_MIN (signed).
  - Response data is the old word and test=2'b00.
  - The new value is written at the accept edge.
- Undefined: types 3..7 take the unsupported-type path (data 0, test 2'b11, no write).

Test Plan:
- Reset, then WRITE addr 0x0000_0010 data 0xDEADBEEF len 0 opaque 0x05, ostream_rdy=1 -> next cycle: response type 1, opaque 0x05, test 0, data 0. Back-to-back READ of 0x10 -> data 0xDEADBEEF.
- ostream_rdy=0, three reads offered on consecutive cycles -> first two accepted, istream_rdy=0 on the third. Raise ostream_rdy -> responses drain in order; third accepted once count<2.
- Word 0x20 preloaded with 0x11223344:
  - READ addr 0x21 len 1 -> 0x00000033.
  - READ addr 0x22 len 2 -> 0x00001122.
  - READ addr 0x23 len 2 -> 0x00000011 (edge truncation).
- Word 0x30 = 0; WRITE addr 0x31 len 2 data 0xAABB -> READ 0x30 returns 0x00AABB00.
- Two requests queued with ostream_val=1, then reset pulsed low mid-stream -> ostream_val=0 immediately. After release, READ of the previously written address returns the retained value.
- With MEM_RESPONDER_AMO_EN: word 0x40 = 5; AMO_ADD data 3 -> resp 5, then READ -> 8. Without the macro: the same request gives test=2'b11, data 0, and READ -> 5.
